// File: rtl/note_mixer_pkg.sv
// Shared constants, FSM state type and scaling table for the note mixer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package note_pkg;

    localparam int NUM_NOTES = 12;
    localparam int CNT_W     = 18;
    localparam int SMP_W     = 8;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        SCALE,
        OUT
    } mix_state_t;

    // Entry n = floor(65280 / n), so hi*LUT[act] >> 8 maps hi/act onto 0..255.
    localparam logic [15:0] SCALE_LUT [0:12] = '{
        16'd0,     16'd65280, 16'd32640, 16'd21760, 16'd16320,
        16'd13056, 16'd10880, 16'd9325,  16'd8160,  16'd7253,
        16'd6528,  16'd5934,  16'd5440
    };

endpackage

// File: rtl/note_mixer_pwm_dac.sv
// 8-bit PWM DAC: free-running counter compared against the current sample.
// Latency: one cycle from sample to pwm_out (registered compare).
// Backpressure: none; sample is taken every cycle.
module pwm_dac
    import note_pkg::*;
(
    input  logic             clk,
    input  logic             n_rst,
    input  logic [SMP_W-1:0] sample,
    output logic             pwm_out
);

    logic [SMP_W-1:0] pwm_cnt;

    // Counter wraps 255->0; output high while counter is below the sample.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            pwm_cnt <= '0;
            pwm_out <= 1'b0;
        end else begin
            pwm_cnt <= pwm_cnt + 1'b1;
            pwm_out <= (pwm_cnt < sample);
        end
    end

endmodule

// File: rtl/note_mixer.sv
// Mixes square-wave levels of pressed notes into an 8-bit sample, drives a PWM DAC.
// Latency: tick in cycle T -> sample/sample_valid at T+14 (T+16 key path with NOTE_MIXER_KEY_SYNC_EN).
// Backpressure: none; a tick arriving outside IDLE is ignored.
module note_mixer
    import note_pkg::*;
#(
    parameter int SAMPLE_DIV = 256,
    parameter int PWM_W      = 8
)(
    input  logic                       clk,
    input  logic                       n_rst,
    input  logic [NUM_NOTES-1:0]       keys,
    input  logic [NUM_NOTES*CNT_W-1:0] count_in,
    input  logic [NUM_NOTES*CNT_W-1:0] lim_in,
    output logic [SMP_W-1:0]           sample,
    output logic                       sample_valid,
    output logic                       busy,
    output logic                       pwm_out
);

    if (SAMPLE_DIV < 16 || SAMPLE_DIV > 65535) begin : g_bad_div
        $error("note_mixer: SAMPLE_DIV must be within 16..65535");
    end
    if (PWM_W != SMP_W) begin : g_bad_pwm
        $error("note_mixer: PWM_W must equal the sample width (8)");
    end

    logic [15:0]          div;
    logic                 tick;
    logic [NUM_NOTES-1:0] key_src;
    logic [NUM_NOTES-1:0] key_q;
    mix_state_t           state;
    logic [3:0]           idx;
    logic [3:0]           hi_sum;
    logic [3:0]           act_sum;
    logic [CNT_W-1:0]     cnt_sel;
    logic [CNT_W-1:0]     lim_sel;
    logic                 note_hi;
    logic [19:0]          prod;
    logic [11:0]          shifted;
    logic [SMP_W-1:0]     res;

`ifdef NOTE_MIXER_KEY_SYNC_EN
    logic [NUM_NOTES-1:0] key_s1;
    logic [NUM_NOTES-1:0] key_s2;

    // Two-flop synchroniser for keys coming from another clock domain.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            key_s1 <= '0;
            key_s2 <= '0;
        end else begin
            key_s1 <= keys;
            key_s2 <= key_s1;
        end
    end
    assign key_src = key_s2;
`else
    assign key_src = keys;
`endif

    // Sample-rate divider: tick marks the last clock of each sample period.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            div <= '0;
        end else if (tick) begin
            div <= '0;
        end else begin
            div <= div + 16'd1;
        end
    end
    assign tick = (div == 16'(SAMPLE_DIV - 1));

    // Live select of the note under scan; square wave is high in the first half-period.
    always_comb begin
        cnt_sel = count_in[idx*CNT_W +: CNT_W];
        lim_sel = lim_in[idx*CNT_W +: CNT_W];
        note_hi = key_q[idx] && (cnt_sel < (lim_sel >> 1));
    end

    // Normalise hi/act to 0..255; silence when no key is pressed.
    always_comb begin
        prod    = 20'(hi_sum) * 20'(SCALE_LUT[act_sum]);
        shifted = 12'(prod >> 8);
        res     = '0;
        if (act_sum != 4'd0) begin
            res = (shifted > 12'd255) ? 8'hFF : shifted[7:0];
        end
    end

    // Mix FSM: snapshot keys, scan twelve notes, scale, publish sample.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state        <= IDLE;
            key_q        <= '0;
            idx          <= '0;
            hi_sum       <= '0;
            act_sum      <= '0;
            sample       <= '0;
            sample_valid <= 1'b0;
            busy         <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    sample_valid <= 1'b0;
                    if (tick) begin
                        key_q   <= key_src;
                        hi_sum  <= '0;
                        act_sum <= '0;
                        idx     <= '0;
                        busy    <= 1'b1;
                        state   <= SCAN;
                    end
                end
                SCAN: begin
                    act_sum <= act_sum + {3'b000, key_q[idx]};
                    hi_sum  <= hi_sum + {3'b000, note_hi};
                    if (idx == 4'(NUM_NOTES - 1)) begin
                        state <= SCALE;
                    end else begin
                        idx <= idx + 4'd1;
                    end
                end
                SCALE: begin
                    sample       <= res;
                    sample_valid <= 1'b1;
                    busy         <= 1'b0;
                    state        <= OUT;
                end
                OUT: begin
                    sample_valid <= 1'b0;
                    state        <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    pwm_dac u_pwm_dac (
        .clk     (clk),
        .n_rst   (n_rst),
        .sample  (sample),
        .pwm_out (pwm_out)
    );

endmodule

// File: tb/tb_note_mixer.sv
// Self-checking bench for note_mixer: directed cases then randomized mixes vs a ratio model.
// Latency: checks busy/sample_valid cycle by cycle from each tick.
// Backpressure: n/a.
module tb_note_mixer;

    localparam int DIV = 32;

    logic         clk;
    logic         n_rst;
    logic [11:0]  keys;
    logic [215:0] count_in;
    logic [215:0] lim_in;
    logic [7:0]   sample;
    logic         sample_valid;
    logic         busy;
    logic         pwm_out;

    int tests;
    int failed;
    int cyc;

    note_mixer #(.SAMPLE_DIV(DIV), .PWM_W(8)) dut (
        .clk          (clk),
        .n_rst        (n_rst),
        .keys         (keys),
        .count_in     (count_in),
        .lim_in       (lim_in),
        .sample       (sample),
        .sample_valid (sample_valid),
        .busy         (busy),
        .pwm_out      (pwm_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Clock edges since reset release; the divider must equal cyc mod DIV.
    always @(posedge clk or negedge n_rst) begin
        if (!n_rst) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            failed++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference: fraction of pressed notes that are high, scaled to 0..255.
    function automatic int model(input logic [11:0] k, input logic [215:0] c, input logic [215:0] l);
        int hi;
        int act;
        int p;
        hi  = 0;
        act = 0;
        for (int i = 0; i < 12; i++) begin
            if (k[i]) begin
                act++;
                if (int'(c[18*i +: 18]) < int'(l[18*i +: 18]) / 2) hi++;
            end
        end
        if (act == 0) return 0;
        p = (hi * (65280 / act)) / 256;
        return (p > 255) ? 255 : p;
    endfunction

    task automatic set_note(input int i, input int c, input int l);
        count_in[18*i +: 18] = 18'(c);
        lim_in[18*i +: 18]   = 18'(l);
    endtask

    // Wait for a tick, then check busy/sample_valid each cycle and the final sample.
    task automatic run_mix(input string tag, input int chg_at, input logic [11:0] new_keys,
                           input int rst_at);
        int exp_s;
        int n;
        repeat (3) @(negedge clk);
        n = 0;
        while (cyc % DIV != DIV - 1) begin
            @(negedge clk);
            n++;
            if (n > 2 * DIV) begin
                check({tag, "_tick_timeout"}, 32'(n), 32'(2 * DIV));
                return;
            end
        end
        exp_s = model(keys, count_in, lim_in);
        for (int i = 1; i <= 14; i++) begin
            @(negedge clk);
            if (i == rst_at) begin
                n_rst = 1'b0;
                #1;
                check({tag, "_rst_sample"}, 32'(sample), 0);
                check({tag, "_rst_valid"}, 32'(sample_valid), 0);
                check({tag, "_rst_busy"}, 32'(busy), 0);
                check({tag, "_rst_pwm"}, 32'(pwm_out), 0);
                @(negedge clk);
                check({tag, "_rst_hold_valid"}, 32'(sample_valid), 0);
                @(negedge clk);
                n_rst = 1'b1;
                return;
            end
            check($sformatf("%s_busy_t%0d", tag, i), 32'(busy), (i <= 13) ? 32'd1 : 32'd0);
            check($sformatf("%s_valid_t%0d", tag, i), 32'(sample_valid), (i == 14) ? 32'd1 : 32'd0);
            if (i == chg_at) keys = new_keys;
        end
        check({tag, "_sample"}, 32'(sample), 32'(exp_s));
    endtask

    task automatic pwm_window(input string tag, input int exp_hi);
        int h;
        h = 0;
        @(negedge clk);
        for (int i = 0; i < 256; i++) begin
            @(negedge clk);
            h += int'(pwm_out);
        end
        check({tag, "_pwm_high"}, 32'(h), 32'(exp_hi));
    endtask

    initial begin
        tests    = 0;
        failed   = 0;
        n_rst    = 1'b0;
        keys     = '0;
        count_in = '0;
        lim_in   = '0;
        repeat (3) @(negedge clk);
        check("reset_sample", 32'(sample), 0);
        check("reset_valid", 32'(sample_valid), 0);
        check("reset_busy", 32'(busy), 0);
        check("reset_pwm", 32'(pwm_out), 0);
        n_rst = 1'b1;

        // No keys: three silent mixes, PWM stays low.
        for (int t = 0; t < 3; t++) run_mix("silent", 0, '0, 0);
        pwm_window("silent", 0);

        // Single note high -> full scale.
        set_note(0, 10, 100);
        keys = 12'h001;
        run_mix("c_high", 0, '0, 0);
        pwm_window("c_high", 255);

        // One high, one low -> half scale (rounded down).
        set_note(1, 90, 100);
        keys = 12'h003;
        run_mix("c_cs", 0, '0, 0);
        pwm_window("c_cs", 127);

        // All notes, counts 0 and limits 2 -> all high.
        for (int i = 0; i < 12; i++) set_note(i, 0, 2);
        keys = 12'hFFF;
        run_mix("all_high", 0, '0, 0);
        // Limits of 1 never produce a high level.
        for (int i = 0; i < 12; i++) set_note(i, 0, 1);
        run_mix("lim_one", 0, '0, 0);

        // Key change mid-mix is ignored by the running mix.
        set_note(0, 10, 100);
        keys = 12'h001;
        run_mix("midchg", 5, 12'h000, 0);
        run_mix("after_chg", 0, '0, 0);

        // Reset mid-mix aborts; next tick gives a full mix.
        keys = 12'h001;
        run_mix("abort", 0, '0, 7);
        run_mix("post_rst", 0, '0, 0);

        // Randomized mixes, including count > lim transients and large 18-bit values.
        for (int t = 0; t < 20; t++) begin
            keys = 12'($urandom);
            for (int i = 0; i < 12; i++) begin
                if ($urandom_range(0, 3) == 0)
                    set_note(i, int'($urandom & 32'h3FFFF), int'($urandom & 32'h3FFFF));
                else
                    set_note(i, int'($urandom_range(0, 300)), int'($urandom_range(0, 300)));
            end
            run_mix($sformatf("rand%0d", t), 0, '0, 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/note_mixer.md
Name: note_mixer

Overview:
- Consumer end of the per-note oscillator counter bank.
- Takes the twelve free-running 18-bit note counters and their limits, and turns the counter phase into a square-wave level for each note.
- At a fixed sample rate, mixes the levels of the pressed keys and normalises the sum to an 8-bit sample.
- Drives that sample out through an 8-bit PWM DAC to the audio pin.

Parameters:
- SAMPLE_DIV, 256: clocks per audio sample; legal range 16..65535; elaboration error outside this range.
- PWM_W, 8: PWM counter width; fixed at 8 and must equal the sample width.

Ports:
- clk  in  1  system clock
- n_rst  in  1  reset, asynchronous, active-low
- keys  in  12  pressed-note mask; bit0=C … bit11=B
- count_in  in  216  packed note counters; note i at [18i+17:18i]
- lim_in  in  216  packed note limits, same packing as count_in
- sample  out  8  last mixed sample, unsigned
- sample_valid  out  1  one-cycle pulse when sample updates
- busy  out  1  high while a mix is in progress
- pwm_out  out  1  PWM DAC output

Behaviour:
- Reset (async assert, sync release):
  - sample=0, sample_valid=0, busy=0, pwm_out=0.
  - State IDLE; sample divider=0; PWM counter=0; accumulators=0.
- Sample divider:
  - Counts 0..SAMPLE_DIV-1, then wraps.
  - tick is high in the cycle where divider==SAMPLE_DIV-1.
- FSM states: IDLE, SCAN, SCALE, OUT.
  - IDLE: on tick, snapshot keys into key_q, clear hi_sum and act_sum, set idx=0, go to SCAN. busy=1 from the next cycle.
  - SCAN: one note per cycle, idx=0..11.
    - act_sum += key_q[idx].
    - hi_sum += key_q[idx] & (count_i < (lim_i>>1)), compared unsigned 18-bit.
    - After idx=11, go to SCALE.
  - SCALE:
    - prod = hi_sum * SCALE_LUT[act_sum] (4b x 16b = 20b).
    - res = prod>>8, clamped to 255.
    - If act_sum==0, res=0.
  - OUT: sample<=res, sample_valid=1 for exactly this cycle, busy=0, go to IDLE.
- Latency: tick in cycle T → SCAN in T+1..T+12 → SCALE in T+13 → new sample and sample_valid visible at T+14.
- A tick outside IDLE is ignored. This cannot occur because SAMPLE_DIV ≥ 16.
- count_in, lim_in and keys are sampled live during SCAN. Keys changing mid-mix do not affect the mix (key_q snapshot).
- lim_i ≤ 1: lim>>1=0, so the note is never high; a pressed note counts toward act_sum but adds 0 to hi_sum.
- count_i > lim_i (transient after a limit change): the plain compare is used; no special handling.
- PWM:
  - 8-bit counter free-runs and wraps 255→0.
  - pwm_out is registered: pwm_cnt < sample.
  - sample=0 → output always low; sample=255 → high 255 of 256 cycles.
- Reset mid-mix aborts immediately; after release the block waits for the next tick.

Optional Feature:
- Macro: NOTE_MIXER_KEY_SYNC_EN.
- Defined: keys pass through a 2-flop synchroniser (reset 0) before the IDLE snapshot. Key-to-mix latency grows by 2 cycles.
- Undefined: keys are snapshotted directly; the caller guarantees keys are synchronous to clk.

Decomposition:
- Shared package note_pkg holds:
  - NUM_NOTES=12, CNT_W=18, SMP_W=8.
  - mix_state_t enum {IDLE, SCAN, SCALE, OUT}.
  - SCALE_LUT[0:12] of 16 bits: entry n = floor(65280/n); entry 0 = 0.
- Sub-module pwm_dac (8-bit counter plus comparator, clk/n_rst, sample in, pwm_out out).
- The FSM, accumulators and scaling stay in note_mixer.

Test Plan:
- Reset then no keys, run 3 ticks → sample_valid pulses at T+14 of each tick, sample=0, pwm_out constantly 0.
- keys=0x001, count_C=10, lim_C=100 → hi=1, act=1 → sample=255; pwm_out high 255/256 cycles.
- keys=0x003, count_C=10/lim_C=100 (high), count_Cs=90/lim_Cs=100 (low) → hi=1, act=2 → sample=127.
- keys=0xFFF, all counts=0, all lims=2 → hi=12, act=12 → sample=255. Then all lims=1 → sample=0.
- Change keys to 0x000 at T+5 of a mix with keys=0x001 high → that mix still outputs 255; the next mix outputs 0.
- Assert n_rst at T+7 → outputs return to reset values at once, no sample_valid; after release the next tick gives a full mix with sample_valid at T+14.
